// File: rtl/reg_bank_dumper.sv
// Debug dump sequencer: walks first_reg..last_reg over the bank's two read ports, two words per fetch.
// Latency start->first beat 2 cycles; a stalled beat holds data/index until out_ready (abort/rst excepted).
module reg_bank_dumper #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rs,
    output logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] b0_dat_q, b0_dat_d, b1_dat_q, b1_dat_d;
    logic [ADDR_W-1:0] b0_idx_q, b0_idx_d, b1_idx_q, b1_idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] cur_nxt;

    // Second read port always looks one entry ahead, wrapping at the top of the bank.
    assign cur_nxt   = ADDR_W'((32'(cur_q) + 1) % NUM_REGS);
    assign rs        = cur_q;
    assign rt        = cur_nxt;
    assign out_valid = (state_q == S_DRAIN);
    assign out_index = b0_idx_q;
    assign out_data  = b0_dat_q;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    // An illegal range passes through DONE with err set but never counts as busy.
    assign busy      = (state_q != S_IDLE) && !err_q;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        b0_dat_d = b0_dat_q;
        b0_idx_d = b0_idx_q;
        b1_dat_d = b1_dat_q;
        b1_idx_d = b1_idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (first_reg <= last_reg) begin
                        cur_d   = first_reg;
                        last_d  = last_reg;
                        err_d   = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                b0_dat_d = read_data1;
                b0_idx_d = cur_q;
                if (cur_q < last_q) begin
                    b1_dat_d = read_data2;
                    b1_idx_d = cur_nxt;
                    cnt_d    = 2'd2;
                end else begin
                    cnt_d    = 2'd1;
                end
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == 2'd2) begin
                        b0_dat_d = b1_dat_q;
                        b0_idx_d = b1_idx_q;
                        cnt_d    = 2'd1;
                    end else begin
                        cnt_d = 2'd0;
                        if (b0_idx_q == last_q) begin
                            state_d = S_DONE;
                        end else begin
                            cur_d   = cur_q + ADDR_W'(2);
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            last_q   <= '0;
            b0_dat_q <= '0;
            b0_idx_q <= '0;
            b1_dat_q <= '0;
            b1_idx_q <= '0;
            cnt_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            b0_dat_q <= b0_dat_d;
            b0_idx_q <= b0_idx_d;
            b1_dat_q <= b1_dat_d;
            b1_idx_q <= b1_idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_dumper.sv
// Bench for reg_bank_dumper: bank model, expected-beat queue and per-cycle compare against it.
module tb_reg_bank_dumper;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] dat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [4:0]  first_reg, last_reg, rs, rt, out_index;
    logic [31:0] read_data1, read_data2, out_data;
    logic        out_valid, busy, done, err;

    logic [31:0] mem [32];
    assign read_data1 = mem[rs];
    assign read_data2 = mem[rt];

    reg_bank_dumper #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_reg(first_reg), .last_reg(last_reg), .rs(rs), .rt(rt),
        .read_data1(read_data1), .read_data2(read_data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    checks = 0, fails = 0;
    beat_t exp_q[$];
    int    exp_done_cyc = -1, exp_done_cnt = 0, done_cnt = 0, done_seen_cyc = 0;
    int    start_cyc = 0, pop_cnt = 0, stall_cnt = 0, rdy_mode = 0;
    logic  exp_err = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready.
    initial begin
        int k;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (k % 4 == 0) || (k % 4 == 3);
                default: out_ready = 1'b0;
            endcase
            k++;
        end
    end

    // Compare process: outputs and inputs are both settled at the falling edge.
    logic        prev_hold = 1'b0, aborted_last = 1'b0;
    logic [4:0]  prev_idx, rt_exp;
    logic [31:0] prev_dat;
    beat_t       head;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rs", rs, 0);
            check("rst_rt", rt, 1);
            prev_hold    = 1'b0;
            aborted_last = 1'b0;
        end else begin
            rt_exp = rs + 5'd1;
            check("rt_is_rs_plus1", rt, rt_exp);
            if (out_valid) check("valid_implies_busy", busy, 1);
            if (aborted_last) begin
                check("abort_valid_drop", out_valid, 0);
                check("abort_busy_drop", busy, 0);
                aborted_last = 1'b0;
            end
            if (prev_hold) begin
                stall_cnt++;
                check("stall_valid_held", out_valid, 1);
                check("stall_index_held", out_index, prev_idx);
                check("stall_data_held", out_data, prev_dat);
            end
            if (out_valid) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    head = exp_q[0];
                    check("beat_index", out_index, head.idx);
                    check("beat_data", out_data, head.dat);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end
            prev_hold = out_valid && !out_ready && !abort;
            prev_idx  = out_index;
            prev_dat  = out_data;
            if (done) begin
                done_cnt++;
                done_seen_cyc = cyc;
                if (exp_done_cyc >= 0) check("done_cycle", cyc, exp_done_cyc);
                check("done_all_beats_out", exp_q.size(), 0);
                check("done_err", err, exp_err);
            end
            if (abort && (busy || done)) begin
                exp_q.delete();
                exp_done_cyc = -1;
                aborted_last = 1'b1;
            end
        end
    end

    task automatic do_start(input logic [4:0] f, input logic [4:0] l, input bit timed);
        int n;
        @(posedge clk);
        #1;
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        start_cyc = cyc;
        pop_cnt   = 0;
        if (f <= l) begin
            for (int i = int'(f); i <= int'(l); i++) exp_q.push_back('{idx: 5'(i), dat: mem[i]});
            n = int'(l) - int'(f) + 1;
            exp_err = 1'b0;
            exp_done_cyc = timed ? start_cyc + 2 + n + (n + 1) / 2 - 1 : -1;
        end else begin
            exp_err = 1'b1;
            exp_done_cyc = start_cyc + 1;
        end
        exp_done_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || done_cnt != exp_done_cnt) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_no_timeout"}, t < 300, 1);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_count"}, done_cnt, exp_done_cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rs"}, rs, 0);
        check({tag, "_rt"}, rt, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_index"}, out_index, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        rst = 1'b1; start = 1'b0; abort = 1'b0; first_reg = '0; last_reg = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full dump 0..31 without backpressure.
        do_start(5'd0, 5'd31, 1'b1);
        wait_end("full");
        check("full_done_at_E49", done_seen_cyc - start_cyc, 49);
        check("full_beats", pop_cnt, 32);

        // Single register.
        do_start(5'd5, 5'd5, 1'b1);
        @(posedge clk);
        #1;
        check("single_valid", out_valid, 1);
        check("single_index", out_index, 5);
        check("single_data", out_data, 32'h1000_0005);
        wait_end("single");
        check("single_done_at_E3", done_seen_cyc - start_cyc, 3);
        check("single_beats", pop_cnt, 1);

        // Odd range under toggling backpressure.
        stall_cnt = 0;
        rdy_mode = 1;
        do_start(5'd3, 5'd6, 1'b0);
        wait_end("odd");
        rdy_mode = 0;
        check("odd_beats", pop_cnt, 4);
        check("odd_stalls_seen", stall_cnt > 0, 1);

        // Illegal range, then a legal one clears err.
        do_start(5'd9, 5'd4, 1'b1);
        check("illegal_err_E1", err, 1);
        check("illegal_done_E1", done, 1);
        check("illegal_busy", busy, 0);
        wait_end("illegal");
        check("illegal_err_sticky", err, 1);
        do_start(5'd0, 5'd1, 1'b1);
        check("legal_clears_err", err, 0);
        wait_end("after_illegal");

        // Abort after beat 10 of 0..31.
        do_start(5'd0, 5'd31, 1'b0);
        t = 0;
        while (pop_cnt < 11 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("abort_reached_beat10", pop_cnt, 11);
        rdy_mode = 2;
        abort = 1'b1;
        exp_done_cnt--;
        @(posedge clk);
        #1;
        abort = 1'b0;
        rdy_mode = 0;
        check("abort_idle_busy", busy, 0);
        wait_end("abort");
        do_start(5'd0, 5'd1, 1'b1);
        wait_end("after_abort");
        check("after_abort_beats", pop_cnt, 2);

        // Asynchronous reset mid-FETCH.
        do_start(5'd0, 5'd31, 1'b0);
        check("fetch_busy", busy, 1);
        exp_q.delete();
        exp_done_cnt--;
        exp_done_cyc = -1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Range ending at 31 with odd start: final fetch wraps rt to 0, wrapped word discarded.
        do_start(5'd29, 5'd31, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("wrap_rs", rs, 31);
        check("wrap_rt", rt, 0);
        wait_end("wrap");
        check("wrap_beats", pop_cnt, 3);
        check("wrap_done_at_E6", done_seen_cyc - start_cyc, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
